// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: pipeline (A) over context-save unit (B), with a B starvation guard.
// Optional build macro DMEM_ARB_BOUND_CHECK_EN rejects 32-bit accesses at the last word address.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        i_a_req,
  input  logic        i_a_we,
  input  logic        i_a_en32,
  input  logic [19:0] i_a_addr,
  input  logic [31:0] i_a_wdata,
  output logic        o_a_gnt,
  output logic        o_a_rvalid,
  output logic [31:0] o_a_rdata,
  output logic        o_a_err,
  input  logic        i_b_req,
  input  logic        i_b_we,
  input  logic        i_b_en32,
  input  logic [19:0] i_b_addr,
  input  logic [31:0] i_b_wdata,
  output logic        o_b_gnt,
  output logic        o_b_rvalid,
  output logic [31:0] o_b_rdata,
  output logic        o_b_err,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_mem_en32,
  output logic [19:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] RDWAIT = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             cmd_we;
  logic             cmd_en32;
  logic [19:0]      cmd_addr;
  logic [31:0]      cmd_wdata;
  logic             owner_b;
  logic [31:0]      a_rdata_hold;
  logic [31:0]      b_rdata_hold;

  logic        b_wins;
  logic        any_req;
  logic        reject;
  logic        issue;
  logic        rdwait;
  logic [31:0] rd_data;

  assign any_req = i_a_req | i_b_req;
  assign b_wins  = i_b_req && (!i_a_req || (starve_cnt == CNT_W'(STARVE_LIMIT)));

`ifdef DMEM_ARB_BOUND_CHECK_EN
  // Upper half of a 32-bit access at the last address would fall outside memory.
  assign reject  = cmd_en32 && (cmd_addr == 20'hFFFFF);
  assign o_a_err = issue && !owner_b && reject;
  assign o_b_err = issue && owner_b && reject;
`else
  assign reject  = 1'b0;
  assign o_a_err = 1'b0;
  assign o_b_err = 1'b0;
`endif

  // Pulses are qualified by reset_b so an aborted access never shows a gnt or rvalid.
  assign issue   = (state == ISSUE) && reset_b;
  assign rdwait  = (state == RDWAIT) && reset_b;
  assign rd_data = reject ? 32'h0 : i_mem_rdata;

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      cmd_we       <= 1'b0;
      cmd_en32     <= 1'b0;
      cmd_addr     <= '0;
      cmd_wdata    <= '0;
      owner_b      <= 1'b0;
      a_rdata_hold <= '0;
      b_rdata_hold <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            cmd_we    <= b_wins ? i_b_we    : i_a_we;
            cmd_en32  <= b_wins ? i_b_en32  : i_a_en32;
            cmd_addr  <= b_wins ? i_b_addr  : i_a_addr;
            cmd_wdata <= b_wins ? i_b_wdata : i_a_wdata;
            owner_b   <= b_wins;
            state     <= ISSUE;
            if (b_wins)
              starve_cnt <= '0;
            else if (i_b_req)
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        ISSUE:   state <= cmd_we ? IDLE : RDWAIT;
        RDWAIT: begin
          state <= IDLE;
          if (owner_b)
            b_rdata_hold <= rd_data;
          else
            a_rdata_hold <= rd_data;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_mem_read  = issue && !cmd_we && !reject;
  assign o_mem_write = issue && cmd_we && !reject;
  assign o_mem_en32  = cmd_en32;
  assign o_mem_addr  = cmd_addr;
  assign o_mem_wdata = cmd_wdata;

  assign o_a_gnt    = issue && !owner_b;
  assign o_b_gnt    = issue && owner_b;
  assign o_a_rvalid = rdwait && !owner_b;
  assign o_b_rvalid = rdwait && owner_b;
  assign o_a_rdata  = (rdwait && !owner_b) ? rd_data : a_rdata_hold;
  assign o_b_rdata  = (rdwait && owner_b) ? rd_data : b_rdata_hold;
  assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: transaction-level reference model predicts grants and read data,
// a monitor compares them against the DUT each cycle; directed cases then randomized traffic.
module tb_dmem_arbiter;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        a_req = 0, a_we = 0, a_en32 = 0, b_req = 0, b_we = 0, b_en32 = 0;
  logic [19:0] a_addr = '0, b_addr = '0;
  logic [31:0] a_wdata = '0, b_wdata = '0;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_read, mem_write, mem_en32, busy;
  logic [19:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .reset_b(reset_b),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_en32(a_en32), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_gnt(a_gnt), .o_a_rvalid(a_rvalid), .o_a_rdata(a_rdata), .o_a_err(a_err),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_en32(b_en32), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_gnt(b_gnt), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata), .o_b_err(b_err),
    .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_en32(mem_en32),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  // Halfword-addressed memory; only the low 9 address bits are decoded by the bench.
  logic [15:0] mem [512] = '{default: 16'h0};
  logic [15:0] ref_mem [512] = '{default: 16'h0};
  logic [19:0] mem_hi_addr;
  int cyc = 0;
  assign mem_hi_addr = mem_addr + 20'd1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) begin
      mem[mem_addr[8:0]] <= mem_wdata[15:0];
      if (mem_en32) mem[mem_hi_addr[8:0]] <= mem_wdata[31:16];
    end
    if (mem_read)
      mem_rdata <= mem_en32 ? {mem[mem_hi_addr[8:0]], mem[mem_addr[8:0]]} : {16'h0, mem[mem_addr[8:0]]};
  end

  typedef struct {
    int          cyc;
    bit          is_rv;
    bit          port;
    bit          we;
    bit          en32;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sb[$];
  bit   gnt_log[$];
  int   tests = 0;
  int   fails = 0;
  int   model_cnt = 0;
  int   free_edge = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one transaction per arbitration, writes occupy 2 cycles and reads 3.
  task automatic model_step();
    int e;
    bit bw;
    exp_t g;
    exp_t r;
    logic [19:0] hi;
    e = cyc + 1;
    if (!reset_b) begin
      model_cnt = 0;
      free_edge = e + 1;
      return;
    end
    if (e < free_edge || !(a_req || b_req)) return;
    bw = b_req && (!a_req || model_cnt == STARVE_LIMIT);
    if (bw) model_cnt = 0;
    else if (b_req) model_cnt++;
    g.cyc = e; g.is_rv = 0; g.port = bw;
    g.we    = bw ? b_we    : a_we;
    g.en32  = bw ? b_en32  : a_en32;
    g.addr  = bw ? b_addr  : a_addr;
    g.wdata = bw ? b_wdata : a_wdata;
    g.rdata = '0;
`ifdef DMEM_ARB_BOUND_CHECK_EN
    g.err = g.en32 && (g.addr == 20'hFFFFF);
`else
    g.err = 0;
`endif
    sb.push_back(g);
    hi = g.addr + 20'd1;
    if (!g.we) begin
      r = g;
      r.cyc = e + 1;
      r.is_rv = 1;
      r.rdata = g.err ? 32'h0 :
                g.en32 ? {ref_mem[hi[8:0]], ref_mem[g.addr[8:0]]} : {16'h0, ref_mem[g.addr[8:0]]};
      sb.push_back(r);
      free_edge = e + 3;
    end else begin
      if (!g.err) begin
        ref_mem[g.addr[8:0]] = g.wdata[15:0];
        if (g.en32) ref_mem[hi[8:0]] = g.wdata[31:16];
      end
      free_edge = e + 2;
    end
  endtask

  task automatic monitor_step();
    exp_t eg;
    exp_t er;
    exp_t x;
    bit hg = 0;
    bit hr = 0;
    logic [8:0] expv;
    logic [8:0] obsv;
    if (!reset_b) begin
      sb.delete();
      check("reset_pulses", {24'h0, a_gnt, b_gnt, a_rvalid, b_rvalid, mem_read, mem_write, a_err, b_err}, 32'h0);
      return;
    end
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      x = sb.pop_front();
      if (x.is_rv) begin er = x; hr = 1; end
      else begin eg = x; hg = 1; end
    end
    expv = {hg && !eg.port, hg && eg.port, hr && !er.port, hr && er.port, hg || hr,
            hg && !eg.we && !eg.err, hg && eg.we && !eg.err, hg && eg.err && !eg.port, hg && eg.err && eg.port};
    obsv = {a_gnt, b_gnt, a_rvalid, b_rvalid, busy, mem_read, mem_write, a_err, b_err};
    check("ctrl gnt_a,gnt_b,rv_a,rv_b,busy,rd,wr,err_a,err_b", {23'h0, obsv}, {23'h0, expv});
    if (a_gnt || b_gnt) begin
      gnt_log.push_back(b_gnt);
      $display("[TB] cyc %0d gnt %s we=%0b en32=%0b addr=%05h wdata=%08h", cyc, b_gnt ? "B" : "A",
               ~mem_read & ~mem_write ? 1'bx : mem_write, mem_en32, mem_addr, mem_wdata);
    end
    if (hg) begin
      check("mem_addr", {12'h0, mem_addr}, {12'h0, eg.addr});
      check("mem_wdata_en32", {mem_wdata[30:0], mem_en32}, {eg.wdata[30:0], eg.en32});
    end
    if (hr) begin
      check(er.port ? "b_rdata" : "a_rdata", er.port ? b_rdata : a_rdata, er.rdata);
      $display("[TB] cyc %0d rvalid %s rdata=%08h", cyc, er.port ? "B" : "A", er.port ? b_rdata : a_rdata);
    end
  endtask

  initial forever begin @(negedge clk); model_step(); end
  initial forever begin @(posedge clk); #2; monitor_step(); end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit port, input bit we, input bit en32, input logic [19:0] addr, input logic [31:0] wdata);
    if (port) begin b_we = we; b_en32 = en32; b_addr = addr; b_wdata = wdata; b_req = 1; end
    else      begin a_we = we; a_en32 = en32; a_addr = addr; a_wdata = wdata; a_req = 1; end
  endtask

  task automatic read_chk(input bit en32, input logic [19:0] addr, input logic [31:0] exp);
    drive(0, 0, en32, addr, 32'h0);
    tick();
    check("rd_gnt_latency", {31'h0, a_gnt}, 32'h1);
    a_req = 0;
    tick();
    check("rd_rvalid_latency", {31'h0, a_rvalid}, 32'h1);
    check("rd_data", a_rdata, exp);
    tick();
    check("rd_busy_done", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    bit pat[6] = '{0, 0, 0, 0, 1, 0};
    int ng;
    int a_wait;
    int b_wait;
    bit w;
    bit e32;
    logic [19:0] ad;

    // Reset held with both ports requesting.
    drive(0, 1, 1, 20'h00010, 32'hDEADBEEF);
    drive(1, 0, 1, 20'h0FFF0, 32'h0);
    tick(); tick();
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_mem_addr", {12'h0, mem_addr}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_en32", {31'h0, mem_en32}, 32'h0);
    check("rst_a_rdata", a_rdata, 32'h0);
    check("rst_b_rdata", b_rdata, 32'h0);
    reset_b = 1;
    tick();
    check("first_arb_a_gnt", {30'h0, a_gnt, b_gnt}, 32'h2);
    check("first_arb_write", {31'h0, mem_write}, 32'h1);
    a_req = 0; b_req = 0;
    tick(); tick();

    read_chk(1, 20'h00010, 32'hDEADBEEF);
    read_chk(0, 20'h00011, 32'h0000DEAD);

    // B-only 16-bit write.
    drive(1, 1, 0, 20'h00020, 32'hABCD1234);
    tick();
    check("b_only_gnt", {31'h0, b_gnt}, 32'h1);
    check("b_only_write", {31'h0, mem_write}, 32'h1);
    b_req = 0;
    tick();
    check("b_only_write_off", {31'h0, mem_write}, 32'h0);
    check("b_only_busy_off", {31'h0, busy}, 32'h0);

    // Continuous contention: A four times, then B once, then A.
    gnt_log.delete();
    ng = 0;
    drive(0, 1, 1, 20'h00100, $urandom);
    drive(1, 0, 1, 20'h0FFF0, 32'h0);
    for (int k = 0; k < 80 && ng < 6; k++) begin
      tick();
      if (b_gnt) begin ng++; b_req = 0; end
      if (a_gnt) begin
        ng++;
        if (ng < 6) drive(0, 1, 1, 20'h00100 + 20'(ng), $urandom);
        else a_req = 0;
      end
    end
    a_req = 0; b_req = 0;
    tick(); tick(); tick();
    check("starve_grants", gnt_log.size(), 6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++)
      check($sformatf("starve_order_%0d", i), {31'h0, gnt_log[i]}, {31'h0, pat[i]});

    // Reset during RDWAIT of an A read aborts it.
    drive(0, 0, 1, 20'h00010, 32'h0);
    tick();
    a_req = 0;
    tick();
    reset_b = 0;
    #1;
    check("abort_rvalid", {31'h0, a_rvalid}, 32'h0);
    tick();
    check("abort_idle", {31'h0, busy}, 32'h0);
    reset_b = 1;
    read_chk(1, 20'h00010, 32'hDEADBEEF);

    // Read at the last address with a 32-bit access.
    drive(0, 0, 1, 20'hFFFFF, 32'h0);
    tick();
    check("bound_gnt", {31'h0, a_gnt}, 32'h1);
`ifdef DMEM_ARB_BOUND_CHECK_EN
    check("bound_err_rd", {30'h0, a_err, mem_read}, 32'h2);
`else
    check("bound_err_rd", {30'h0, a_err, mem_read}, 32'h1);
`endif
    a_req = 0;
    tick();
    check("bound_rvalid", {31'h0, a_rvalid}, 32'h1);
`ifdef DMEM_ARB_BOUND_CHECK_EN
    check("bound_rdata", a_rdata, 32'h0);
`endif
    tick();

    // Randomized traffic; each request is held until granted.
    a_wait = 0; b_wait = 0;
    for (int k = 0; k < 1500; k++) begin
      tick();
      if (a_gnt) begin a_req = 0; a_wait = 0; end
      if (b_gnt) begin b_req = 0; b_wait = 0; end
      if (a_req) begin
        a_wait++;
        if (a_wait > 40) begin check("a_req_timeout", a_wait, 0); a_req = 0; a_wait = 0; end
      end else if ($urandom_range(0, 2) == 0) begin
        w = 1'($urandom_range(0, 1)); e32 = 1'($urandom_range(0, 1));
        ad = ($urandom_range(0, 15) == 0) ? 20'hFFFFF : 20'($urandom_range(0, 63));
        drive(0, w, e32, ad, $urandom);
      end
      if (b_req) begin
        b_wait++;
        if (b_wait > 40) begin check("b_req_timeout", b_wait, 0); b_req = 0; b_wait = 0; end
      end else if ($urandom_range(0, 2) == 0) begin
        w = 1'($urandom_range(0, 1)); e32 = 1'($urandom_range(0, 1));
        ad = ($urandom_range(0, 15) == 0) ? 20'hFFFFF : 20'($urandom_range(0, 63));
        drive(1, w, e32, ad, $urandom);
      end
    end
    a_req = 0; b_req = 0;
    repeat (6) tick();
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters:
  - Port A: the pipeline memory stage.
  - Port B: the interrupt/context-save unit, which pushes and pops PC/flags on the stack.
- Registers the winning command, drives the memory's read/write/en32 controls, and routes the registered read data back to the requester that owns it.
- Arbitration is fixed priority, A over B, with a starvation guard for B.

Parameters:
- STARVE_LIMIT, default 4: number of consecutive arbitration losses by B after which B wins the next arbitration.
- CNT_W, default 3: width of the starvation counter. Must satisfy 2**CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  system clock, rising edge.
- reset_b  in  1  synchronous, active-low reset.
- i_a_req  in  1  port A request; fields below must be held stable while req=1.
- i_a_we  in  1  port A write (1) / read (0).
- i_a_en32  in  1  port A 32-bit access (1) / 16-bit access (0).
- i_a_addr  in  20  port A word address.
- i_a_wdata  in  32  port A write data.
- o_a_gnt  out  1  one-cycle pulse: command accepted and issued.
- o_a_rvalid  out  1  one-cycle pulse: o_a_rdata is valid.
- o_a_rdata  out  32  port A read data.
- o_a_err  out  1  one-cycle pulse with gnt: access rejected (optional feature only).
- i_b_req, i_b_we, i_b_en32, i_b_addr, i_b_wdata, o_b_gnt, o_b_rvalid, o_b_rdata, o_b_err: same as port A, for port B.
- o_mem_read  out  1  to memory memRead.
- o_mem_write  out  1  to memory memWrite.
- o_mem_en32  out  1  to memory en32.
- o_mem_addr  out  20  to memory address.
- o_mem_wdata  out  32  to memory data_in.
- i_mem_rdata  in  32  from memory data_out; registered by the memory, valid the cycle after issue.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset (reset_b=0 at a rising edge):
  - state=IDLE; starvation counter=0.
  - All o_* = 0, including o_mem_read, o_mem_write, o_mem_addr and o_mem_wdata.
  - Reset mid-operation aborts any in-flight access. No gnt or rvalid is produced for it; the memory's registered output is ignored.
- FSM states: IDLE, ISSUE, RDWAIT.
- IDLE, arbitration on each rising edge:
  - No req: remain in IDLE.
  - Winner selection:
    - B wins if i_b_req=1 and either i_a_req=0 or counter==STARVE_LIMIT.
    - Otherwise A wins if i_a_req=1.
  - Winner's fields are latched into the command register; owner is recorded; next state is ISSUE.
  - Counter update on the same edge:
    - B requesting and losing: counter increments.
    - B wins: counter clears.
    - B not requesting: counter holds.
- ISSUE (exactly 1 cycle):
  - o_mem_* are driven from the command register: o_mem_read = ~we, o_mem_write = we.
  - The owner's o_x_gnt=1 for this cycle.
  - Next state is RDWAIT for a read, IDLE for a write.
  - Requests are not sampled in ISSUE. The requester must drop req, or present a new command, in the cycle after gnt.
- RDWAIT (exactly 1 cycle):
  - o_mem_read = o_mem_write = 0.
  - Owner's o_x_rvalid=1 and o_x_rdata = i_mem_rdata. For a 16-bit read, bits [31:16] are 0 as returned by the memory.
  - Next state is IDLE.
- Data routing:
  - The non-owner's rdata holds its last value; its rvalid=0.
  - rdata outputs reset to 0.
- Latency from req sampled in IDLE at edge T:
  - gnt in cycle T+1.
  - Read data valid in cycle T+2.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- Simultaneous A and B requests: A wins unless the starvation counter has reached STARVE_LIMIT.
- B-only requests are never delayed.
- Address wrap: none. o_mem_addr = latched address unmodified; the memory itself accesses addr and addr+1 for en32.
- o_x_err = 0 at all times unless the optional feature is enabled.

Optional Feature:
- Macro: DMEM_ARB_BOUND_CHECK_EN.
- When defined:
  - A latched command with en32=1 and addr=20'hFFFFF is rejected, because its upper half would lie beyond the addressable range.
  - ISSUE still occurs, with o_x_gnt=1 and o_x_err=1, but o_mem_read = o_mem_write = 0.
  - A rejected read still passes through RDWAIT, with rvalid=1 and rdata=0.
  - Arbitration and counter updates are unaffected.
- When undefined:
  - No check is made; the access is issued unmodified.
  - o_a_err and o_b_err are tied to 0.

Test Plan:
- Reset: hold reset_b=0 for 2 cycles with both req=1 → all outputs 0, o_busy=0; first arbitration occurs at the first edge with reset_b=1.
- A write 32'hDEADBEEF to 20'h00010 (en32=1), then A read of the same address → gnt pulses; the read's rvalid arrives 2 cycles after its req is sampled with o_a_rdata=32'hDEADBEEF; a 16-bit read of 20'h00011 returns 32'h0000DEAD.
- A and B request together continuously (B read 20'h0FFF0) → A granted 4 times, then B granted once, then A again; counter returns to 0 after B's grant.
- B-only 16-bit write 16'h1234 to 20'h00020 → o_b_gnt in the cycle after req is sampled, o_mem_write=1 for exactly 1 cycle, o_busy returns to 0 next cycle.
- reset_b driven 0 during RDWAIT of an A read → o_a_rvalid never asserts; state=IDLE; the next A read completes normally.
- With DMEM_ARB_BOUND_CHECK_EN: A 32-bit read at 20'hFFFFF → o_a_gnt=1 and o_a_err=1, o_mem_read=0, then o_a_rvalid=1 with rdata=0. Without the macro: o_mem_read=1 and o_a_err=0.
